wb_sdram_arbiter: RTL
=====================

# wb_sdram_arbiter

Two-master Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller between two requesters on `sys_clk`. It uses round-robin arbitration with grant held for a whole `cyc` cycle, so bursts are never split. It withholds all grants until the SDRAM reports init done, and it has a stall watchdog that returns an error to a master whose strobe goes unacknowledged. It sits between the system masters (e.g. CPU port, DMA port) and the SDRAM controller's `wb_*` port.

## Interface
Parameters:
- `dw`, 32: Wishbone data width; `dw/8` byte selects.
- `aw`, 26: Wishbone address width.
- `TIMEOUT`, 256: max cycles `s_stb_o` may stay high without `s_ack_i`; 0 disables the watchdog.

Ports (`X` ∈ {0,1}, one set per master):
- `sys_clk` in 1: single clock; all logic on its rising edge.
- `RESETN` in 1: asynchronous, active-low reset.
- `sdr_init_done` in 1: SDRAM init complete; no grant while low.
- `mX_cyc_i` in 1: master X bus cycle request.
- `mX_stb_i` in 1: master X strobe.
- `mX_we_i` in 1: master X write enable (1 = write).
- `mX_addr_i` in aw: master X address.
- `mX_dat_i` in dw: master X write data.
- `mX_sel_i` in dw/8: master X byte enables.
- `mX_cti_i` in 3: master X cycle type (passed through).
- `mX_ack_o` out 1: ack to master X.
- `mX_err_o` out 1: watchdog error to master X.
- `mX_dat_o` out dw: read data; equals `s_dat_i` for both masters.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1: to SDRAM controller.
- `s_addr_o` out aw: to SDRAM controller.
- `s_dat_o` out dw: to SDRAM controller.
- `s_sel_o` out dw/8: to SDRAM controller.
- `s_cti_o` out 3: to SDRAM controller.
- `s_ack_i` in 1: slave acknowledge.
- `s_dat_i` in dw: slave read data.
- `grant_o` out 2: one-hot current owner; 00 when none.
- `busy_o` out 1: state ≠ IDLE.

## Operation
- **States:** IDLE, BUSY, ERR, DRAIN. Registered `owner` (1 bit), `last` (1 bit, reset 1), and watchdog counter `wd` (width `$clog2(TIMEOUT+1)`).
- **IDLE → BUSY:** requires `sdr_init_done` and at least one `mX_cyc_i`.
  - Only one request: grant that master.
  - Both request: grant the master ≠ `last`, so master 0 wins the first tie after reset.
  - On grant, `owner` ← winner and `last` ← winner.
- **BUSY:** slave outputs are a combinational mux of `owner`'s inputs. `s_cyc_o = mOwner_cyc_i`; `s_stb_o = mOwner_stb_i`. `mOwner_ack_o = s_ack_i`; the other ack is held 0. `cti` is ignored for arbitration, so the grant is held across any burst.
- **BUSY → IDLE:** when `mOwner_cyc_i` = 0 at the clock edge. A pending other master is granted on the following edge, giving exactly one dead cycle between owners.
- **Watchdog:**
  - In BUSY, `wd` increments each cycle `s_stb_o`=1 and `s_ack_i`=0, and clears on ack or when stb is low.
  - When `wd` = TIMEOUT−1 with stb=1 and ack=0, the next state is ERR.
  - An ack arriving in that same cycle wins, and the FSM stays in BUSY.
- **ERR:** lasts one cycle. `mOwner_err_o`=1; `s_cyc_o`, `s_stb_o` and all acks are 0. Next state is DRAIN.
- **DRAIN:** slave outputs and acks held 0. Waits for `mOwner_cyc_i`=0, then returns to IDLE. `last` is unchanged, so the other master has priority next.
- **Idle outputs:** in IDLE, ERR and DRAIN, `s_cyc_o`/`s_stb_o`=0 and the slave address/data/sel/we/cti outputs are 0. A late `s_ack_i` outside BUSY is dropped.
- **Init gating:** if `sdr_init_done` falls while in BUSY, the current cycle completes; no new grant is issued until it rises again.
- **Async reset:** `RESETN` low mid-transfer forces IDLE immediately: `grant_o`=00, `s_cyc_o`=0, all acks/errs 0, `wd`=0.

## Timing
- **Reset values:** state IDLE, `owner`=0, `last`=1, `wd`=0. All outputs 0 except `mX_dat_o`, which follows `s_dat_i`.
- **Grant latency:** `cyc` sampled high in IDLE at edge k → `grant_o`/`s_cyc_o` high from cycle k+1.
- **Pass-through:** ack and data to the master are combinational from the slave in BUSY, with 0 added cycles.
- **Error timing:** `err` asserts TIMEOUT cycles after stb first goes high unacknowledged; it is a single-cycle pulse.
- **Release:** owner drops `cyc` at edge j → IDLE from cycle j+1 → next grant visible at cycle j+2.

## Test plan
- **Init gating:** `sdr_init_done`=0, m0 requests for 10 cycles → `grant_o`=00, `s_cyc_o`=0. Raise init → `grant_o`=01 on the next cycle.
- **Simultaneous first requests:** both masters request in the same cycle after reset → m0 granted. m0 drops `cyc` → one dead cycle → m1 granted (`grant_o`=10). Both re-request → m0 wins.
- **Burst integrity:** m0 issues a 4-beat burst (cti 010,010,010,111) while m1 requests throughout → 4 acks routed to m0 only, `m1_ack_o`=0, and m1 granted only after m0 drops `cyc`.
- **Watchdog timeout:** TIMEOUT=8, slave never acks → `m0_err_o` pulses for exactly 1 cycle, 8 cycles after stb, and `s_cyc_o` is 0 from then. With m0 holding `cyc` for 5 more cycles, `grant_o` remains 01 (DRAIN) until m0 releases.
- **Ack beats watchdog:** ack arrives in the same cycle as the TIMEOUT boundary → no err, and the transfer completes normally.
- **Reset mid-transfer:** assert `RESETN` low during m1 BUSY → all outputs 0 asynchronously. After release, a tie goes to m0.

Source files
------------

// File: rtl/wb_sdram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller.
// Grant is held for a whole cyc, gated by sdr_init_done, with a stall watchdog.
//
// Ports:
//   sys_clk, RESETN        clock, async active-low reset
//   sdr_init_done          SDRAM ready; no new grant while low
//   mX_*_i / mX_*_o        Wishbone master ports X = 0,1 (ack/err/dat out)
//   s_*_o / s_*_i          Wishbone port towards the SDRAM controller
//   grant_o                one-hot current owner, 00 when idle
//   busy_o                 arbiter not idle
module wb_sdram_arbiter #(
    parameter int dw      = 32,
    parameter int aw      = 26,
    parameter int TIMEOUT = 256
) (
    input  logic            sys_clk,
    input  logic            RESETN,
    input  logic            sdr_init_done,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [aw-1:0]   m0_addr_i,
    input  logic [dw-1:0]   m0_dat_i,
    input  logic [dw/8-1:0] m0_sel_i,
    input  logic [2:0]      m0_cti_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [dw-1:0]   m0_dat_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [aw-1:0]   m1_addr_i,
    input  logic [dw-1:0]   m1_dat_i,
    input  logic [dw/8-1:0] m1_sel_i,
    input  logic [2:0]      m1_cti_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [dw-1:0]   m1_dat_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [aw-1:0]   s_addr_o,
    output logic [dw-1:0]   s_dat_o,
    output logic [dw/8-1:0] s_sel_o,
    output logic [2:0]      s_cti_o,
    input  logic            s_ack_i,
    input  logic [dw-1:0]   s_dat_i,

    output logic [1:0]      grant_o,
    output logic            busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // Keep at least one counter bit so TIMEOUT=0 still elaborates.
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WDL = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WDW-1:0] WD_LAST = WDL[WDW-1:0];

    logic [1:0]     state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           win;

    logic            own_cyc;
    logic            own_stb;
    logic            own_we;
    logic [aw-1:0]   own_addr;
    logic [dw-1:0]   own_dat;
    logic [dw/8-1:0] own_sel;
    logic [2:0]      own_cti;
    logic            in_busy;
    logic            in_err;

    assign own_cyc  = owner_q ? m1_cyc_i  : m0_cyc_i;
    assign own_stb  = owner_q ? m1_stb_i  : m0_stb_i;
    assign own_we   = owner_q ? m1_we_i   : m0_we_i;
    assign own_addr = owner_q ? m1_addr_i : m0_addr_i;
    assign own_dat  = owner_q ? m1_dat_i  : m0_dat_i;
    assign own_sel  = owner_q ? m1_sel_i  : m0_sel_i;
    assign own_cti  = owner_q ? m1_cti_i  : m0_cti_i;

    // On a tie the master that did not win last time goes first.
    always_comb begin
        win = 1'b0;
        case ({m1_cyc_i, m0_cyc_i})
            2'b11:   win = ~last_q;
            2'b10:   win = 1'b1;
            default: win = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wd_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (sdr_init_done && (m0_cyc_i || m1_cyc_i)) begin
                    state_d = S_BUSY;
                    owner_d = win;
                    last_d  = win;
                end
            end
            S_BUSY: begin
                if (!own_cyc) begin
                    state_d = S_IDLE;
                end else if (TIMEOUT != 0 && own_stb && !s_ack_i) begin
                    // An ack in the boundary cycle takes this branch off.
                    if (wd_q == WD_LAST) state_d = S_ERR;
                    else                 wd_d    = wd_q + 1'b1;
                end
            end
            S_ERR: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!own_cyc) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    assign in_busy = (state_q == S_BUSY);
    assign in_err  = (state_q == S_ERR);
    assign busy_o  = (state_q != S_IDLE);

    // Ownership stays visible through ERR and DRAIN.
    assign grant_o = busy_o ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    assign s_cyc_o  = in_busy & own_cyc;
    assign s_stb_o  = in_busy & own_stb;
    assign s_we_o   = in_busy & own_we;
    assign s_addr_o = in_busy ? own_addr : '0;
    assign s_dat_o  = in_busy ? own_dat  : '0;
    assign s_sel_o  = in_busy ? own_sel  : '0;
    assign s_cti_o  = in_busy ? own_cti  : 3'b000;

    assign m0_ack_o = in_busy & ~owner_q & s_ack_i;
    assign m1_ack_o = in_busy &  owner_q & s_ack_i;
    assign m0_err_o = in_err  & ~owner_q;
    assign m1_err_o = in_err  &  owner_q;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
